// File: rtl/spi_master_shifter_if.sv
// Bundle between the AXI-Lite register block, the SPI mode-0 shifter and the SPI pins.
// The master modport is the register-block/pin side; slave is the shifter itself.
interface spi_master_shifter_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              SPI_MOSI;
    logic              SPI_MISO;
    logic              SPI_SCK;

    modport master (
        output tx_data, tx_valid, SPI_MISO,
        input  tx_ready, rx_data, rx_valid, busy, SPI_MOSI, SPI_SCK
    );

    modport slave (
        input  tx_data, tx_valid, SPI_MISO,
        output tx_ready, rx_data, rx_valid, busy, SPI_MOSI, SPI_SCK
    );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI mode-0 serial engine: accepts one word, shifts it out MSB first on MOSI while
// sampling MISO on SCK rising edges, then returns the received word with a one-cycle pulse.
module spi_master_shifter #(
    parameter int DATA_W   = 8,
    parameter int HALF_DIV = 2
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    spi_master_shifter_if.slave  bus
);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int DIV_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              mosi_q;

    logic div_tick;
    logic accept;
    logic sck_rise;
    logic sck_fall;
    logic frame_done;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // SCK is a pure decode of the state, so it falls together with reset.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        sck_rise   = 1'b0;
        sck_fall   = 1'b0;
        frame_done = 1'b0;
        div_tick   = (div_cnt == DIV_LAST);
        case (state)
            IDLE: begin
                if (bus.tx_valid) begin
                    state_next = LOW;
                    accept     = 1'b1;
                end
            end
            LOW: begin
                if (div_tick) begin
                    state_next = HIGH;
                    sck_rise   = 1'b1;
                end
            end
            HIGH: begin
                if (div_tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_next = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        state_next = LOW;
                        sck_fall   = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;

            if (accept) begin
                tx_shift <= bus.tx_data;
                mosi_q   <= bus.tx_data[DATA_W-1];
                bit_cnt  <= '0;
                div_cnt  <= '0;
            end else if (state != IDLE) begin
                div_cnt <= div_tick ? '0 : div_cnt + DIV_W'(1);
            end

            if (sck_rise) begin
                rx_shift <= {rx_shift[DATA_W-2:0], bus.SPI_MISO};
            end

            // The next MOSI bit is the one just below the current MSB of tx_shift.
            if (sck_fall) begin
                tx_shift <= tx_shift << 1;
                mosi_q   <= tx_shift[DATA_W-2];
                bit_cnt  <= bit_cnt + BIT_W'(1);
            end

            if (frame_done) begin
                rx_data_q  <= rx_shift;
                rx_valid_q <= 1'b1;
                mosi_q     <= 1'b0;
            end
        end
    end

    assign bus.SPI_SCK  = (state == HIGH);
    assign bus.SPI_MOSI = mosi_q;
    assign bus.tx_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed bench for spi_master_shifter: an 8-bit/HALF_DIV=2 instance for framing,
// back-to-back and reset cases, and a 16-bit/HALF_DIV=1 instance for the fast-SCK case.
module tb_spi_master_shifter;
    logic ACLK;
    logic ARESETn;
    logic loopback0;
    logic miso_drv;
    int   total;
    int   bad;

    spi_master_shifter_if #(.DATA_W(8))  bus0 ();
    spi_master_shifter_if #(.DATA_W(16)) bus1 ();

    spi_master_shifter #(.DATA_W(8), .HALF_DIV(2)) dut0 (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus0)
    );

    spi_master_shifter #(.DATA_W(16), .HALF_DIV(1)) dut1 (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus1)
    );

    assign bus0.SPI_MISO = loopback0 ? bus0.SPI_MOSI : miso_drv;
    assign bus1.SPI_MISO = bus1.SPI_MOSI;

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [7:0] tx;
        bit         use_slave;
        logic [7:0] slave_word;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs [5];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic [15:0] data, input string tag);
        logic ready;
        @(negedge ACLK);
        if (sel == 1) begin
            bus1.tx_data  = data;
            bus1.tx_valid = 1'b1;
            ready         = bus1.tx_ready;
        end else begin
            bus0.tx_data  = data[7:0];
            bus0.tx_valid = 1'b1;
            ready         = bus0.tx_ready;
        end
        checkOutput({tag, "_ready_before_accept"}, 32'(ready), 32'd1);
        @(posedge ACLK);
        #1;
        bus0.tx_valid = 1'b0;
        bus1.tx_valid = 1'b0;
    endtask

    // One complete frame; n counts ACLK edges after the accepting edge.
    task automatic runFrame(input int sel, input logic [15:0] tx, input bit use_slave,
                            input logic [15:0] slave_word, input logic [15:0] exp_rx, input string tag);
        int         dw = (sel == 1) ? 16 : 8;
        int         hd = (sel == 1) ? 1 : 2;
        int         first_valid = -1;
        int         valid_cnt = 0;
        int         rise_cnt = 0;
        int         timing_err = 0;
        int         slave_idx = 0;
        logic       prev_sck = 1'b0;
        logic       sck;
        logic       mosi;
        logic       rv;
        logic       busy_now;
        logic [15:0] mosi_bits = '0;
        logic [15:0] rx_got = '0;
        logic [15:0] rx_now;
        if (sel == 0) begin
            loopback0 = !use_slave;
            miso_drv  = slave_word[7];
        end
        applyStimulus(sel, tx, tag);
        for (int n = 0; n < 150; n++) begin
            @(negedge ACLK);
            sck      = (sel == 1) ? bus1.SPI_SCK  : bus0.SPI_SCK;
            mosi     = (sel == 1) ? bus1.SPI_MOSI : bus0.SPI_MOSI;
            rv       = (sel == 1) ? bus1.rx_valid : bus0.rx_valid;
            busy_now = (sel == 1) ? bus1.busy     : bus0.busy;
            rx_now   = (sel == 1) ? bus1.rx_data  : {8'h00, bus0.rx_data};
            if (n == 0) checkOutput({tag, "_busy_after_accept"}, 32'(busy_now), 32'd1);
            if (sck && !prev_sck) begin
                if (n != (2 * rise_cnt + 1) * hd) timing_err++;
                mosi_bits = {mosi_bits[14:0], mosi};
                rise_cnt++;
            end
            if (!sck && prev_sck) begin
                if (n != 2 * rise_cnt * hd) timing_err++;
                if (use_slave) begin
                    slave_idx++;
                    miso_drv = (slave_idx < 8) ? slave_word[7 - slave_idx] : 1'b0;
                end
            end
            if (rv) begin
                valid_cnt++;
                if (first_valid < 0) begin
                    first_valid = n;
                    rx_got      = rx_now;
                end
            end
            prev_sck = sck;
            if (first_valid >= 0 && n >= first_valid + 3) break;
        end
        checkOutput({tag, "_latency"}, 32'(first_valid), 32'(2 * dw * hd));
        checkOutput({tag, "_rx_data"}, 32'(rx_got), 32'(exp_rx));
        checkOutput({tag, "_rx_held"}, 32'((sel == 1) ? bus1.rx_data : {8'h00, bus0.rx_data}), 32'(exp_rx));
        checkOutput({tag, "_valid_width"}, 32'(valid_cnt), 32'd1);
        checkOutput({tag, "_sck_rises"}, 32'(rise_cnt), 32'(dw));
        checkOutput({tag, "_sck_timing_errs"}, 32'(timing_err), 32'd0);
        checkOutput({tag, "_mosi_bits"}, 32'(mosi_bits), 32'(tx));
        checkOutput({tag, "_ready_after"}, 32'((sel == 1) ? bus1.tx_ready : bus0.tx_ready), 32'd1);
    endtask

    initial begin
        int   first_at;
        int   second_at;
        int   accept2;
        int   pulses;
        int   rises;
        logic prev_busy;
        logic prev_sck;
        logic [7:0] rx1;
        logic [7:0] rx2;
        logic valid_seen;

        total         = 0;
        bad           = 0;
        ARESETn       = 1'b0;
        loopback0     = 1'b1;
        miso_drv      = 1'b0;
        bus0.tx_data  = '0;
        bus0.tx_valid = 1'b0;
        bus1.tx_data  = '0;
        bus1.tx_valid = 1'b0;

        vecs[0] = '{tx: 8'hA5, use_slave: 1'b0, slave_word: 8'h00, exp_rx: 8'hA5};
        vecs[1] = '{tx: 8'hFF, use_slave: 1'b1, slave_word: 8'h3C, exp_rx: 8'h3C};
        vecs[2] = '{tx: 8'h00, use_slave: 1'b1, slave_word: 8'hC3, exp_rx: 8'hC3};
        vecs[3] = '{tx: 8'h5A, use_slave: 1'b0, slave_word: 8'h00, exp_rx: 8'h5A};
        vecs[4] = '{tx: 8'h81, use_slave: 1'b1, slave_word: 8'h7E, exp_rx: 8'h7E};

        #12;
        checkOutput("reset_sck",      32'(bus0.SPI_SCK),  32'd0);
        checkOutput("reset_mosi",     32'(bus0.SPI_MOSI), 32'd0);
        checkOutput("reset_tx_ready", 32'(bus0.tx_ready), 32'd1);
        checkOutput("reset_busy",     32'(bus0.busy),     32'd0);
        checkOutput("reset_rx_valid", 32'(bus0.rx_valid), 32'd0);
        checkOutput("reset_rx_data",  32'(bus0.rx_data),  32'd0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        repeat (2) @(negedge ACLK);

        for (int i = 0; i < 5; i++) begin
            runFrame(0, {8'h00, vecs[i].tx}, vecs[i].use_slave, {8'h00, vecs[i].slave_word},
                     {8'h00, vecs[i].exp_rx}, $sformatf("v%0d", i));
        end

        // Back-to-back: tx_valid stays high across the whole first frame while tx_data changes.
        $display("[TB] back-to-back frames");
        loopback0 = 1'b1;
        first_at  = -1;
        second_at = -1;
        accept2   = -1;
        pulses    = 0;
        prev_busy = 1'b1;
        rx1       = '0;
        rx2       = '0;
        @(negedge ACLK);
        bus0.tx_data  = 8'h12;
        bus0.tx_valid = 1'b1;
        @(posedge ACLK);
        #1;
        bus0.tx_data = 8'h34;
        for (int n = 0; n < 120; n++) begin
            @(negedge ACLK);
            if (bus0.rx_valid) begin
                pulses++;
                if (pulses == 1) begin
                    first_at = n;
                    rx1      = bus0.rx_data;
                end else if (pulses == 2) begin
                    second_at = n;
                    rx2       = bus0.rx_data;
                end
            end
            if (bus0.busy && !prev_busy && accept2 < 0) begin
                accept2       = n;
                bus0.tx_valid = 1'b0;
            end
            prev_busy = bus0.busy;
            if (second_at >= 0 && n >= second_at + 3) break;
        end
        bus0.tx_valid = 1'b0;
        checkOutput("b2b_first_valid_at",  32'(first_at),  32'd32);
        checkOutput("b2b_second_accept",   32'(accept2),   32'd33);
        checkOutput("b2b_second_valid_at", 32'(second_at), 32'd65);
        checkOutput("b2b_pulse_cycles",    32'(pulses),    32'd2);
        checkOutput("b2b_rx_first",        32'(rx1),       32'h12);
        checkOutput("b2b_rx_second",       32'(rx2),       32'h34);

        // Wide/fast instance: SCK toggles every ACLK cycle.
        runFrame(1, 16'hBEEF, 1'b0, 16'h0000, 16'hBEEF, "wide");

        // Abort a frame after the third SCK rising edge.
        $display("[TB] reset mid-frame");
        loopback0 = 1'b1;
        rises     = 0;
        prev_sck  = 1'b0;
        applyStimulus(0, 16'h00F0, "abort");
        for (int n = 0; n < 40; n++) begin
            @(negedge ACLK);
            if (bus0.SPI_SCK && !prev_sck) rises++;
            prev_sck = bus0.SPI_SCK;
            if (rises == 3) break;
        end
        checkOutput("abort_pre_sck",  32'(bus0.SPI_SCK),  32'd1);
        checkOutput("abort_pre_mosi", 32'(bus0.SPI_MOSI), 32'd1);
        #1;
        ARESETn = 1'b0;
        #1;
        checkOutput("abort_sck",      32'(bus0.SPI_SCK),  32'd0);
        checkOutput("abort_mosi",     32'(bus0.SPI_MOSI), 32'd0);
        checkOutput("abort_busy",     32'(bus0.busy),     32'd0);
        checkOutput("abort_tx_ready", 32'(bus0.tx_ready), 32'd1);
        checkOutput("abort_rx_data",  32'(bus0.rx_data),  32'd0);
        valid_seen = 1'b0;
        repeat (3) begin
            @(negedge ACLK);
            valid_seen = valid_seen | bus0.rx_valid;
        end
        ARESETn = 1'b1;
        repeat (40) begin
            @(negedge ACLK);
            valid_seen = valid_seen | bus0.rx_valid;
        end
        checkOutput("abort_no_valid", 32'(valid_seen), 32'd0);
        runFrame(0, 16'h0081, 1'b0, 16'h0000, 16'h0081, "after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
